register_file_16x32: RTL

//  16 x 32-bit general register file of the 4215 RISC datapath.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/dec_4to16.sv | 17 +
 rtl/register_file_16x32.sv | 90 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and types for the 16 x 32-bit register file.
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned NREGS  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [NREGS-1:0]  busy_vec_t;

endpackage

// File: rtl/dec_4to16.sv
// One-hot decoder with enable; an all-zero output means no register selected.
module dec_4to16
    import regfile_pkg::*;
(
    input  logic      en_i,
    input  reg_addr_t addr_i,
    output busy_vec_t onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/register_file_16x32.sv
// 16 x 32-bit register file with three combinational read ports and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module register_file_16x32
    import regfile_pkg::*;
(
    input  logic      Clk,
    input  logic      Rst_n,
    input  reg_addr_t In_RD,
    input  reg_data_t In_PW,
    input  logic      Ld_RF,
    input  reg_addr_t In_RA,
    input  reg_addr_t In_RB,
    input  reg_addr_t In_RC,
    output reg_data_t Out_PA,
    output reg_data_t Out_PB,
    output reg_data_t Out_PC,
    input  logic      Rsv_En,
    input  reg_addr_t Rsv_Addr,
    output logic      Out_BusyA,
    output logic      Out_BusyB,
    output logic      Out_BusyC,
    output logic      Out_AnyBusy
);

    reg_data_t regs_q [NREGS];
    busy_vec_t busy_q, busy_d;
    busy_vec_t wr_oh, rsv_oh;

    reg_addr_t rd_addr [3];
    reg_data_t rd_data [3];
    logic      rd_busy [3];

    dec_4to16 u_dec_wr (
        .en_i     (Ld_RF),
        .addr_i   (In_RD),
        .onehot_o (wr_oh)
    );

    dec_4to16 u_dec_rsv (
        .en_i     (Rsv_En),
        .addr_i   (Rsv_Addr),
        .onehot_o (rsv_oh)
    );

    // Reservation is applied after the clear so a same-register collision stays busy.
    assign busy_d = (busy_q & ~wr_oh) | rsv_oh;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < NREGS; i++) begin
                if (wr_oh[i]) begin
                    regs_q[i] <= In_PW;
                end
            end
        end
    end

    assign rd_addr[0] = In_RA;
    assign rd_addr[1] = In_RB;
    assign rd_addr[2] = In_RC;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
            rd_busy[p] = busy_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            // Gated by Rst_n so outputs stay zero while reset is held.
            if (Rst_n && Ld_RF && (rd_addr[p] == In_RD)) begin
                rd_data[p] = In_PW;
                rd_busy[p] = Rsv_En && (Rsv_Addr == rd_addr[p]);
            end
`endif
        end
    end

    assign Out_PA      = rd_data[0];
    assign Out_PB      = rd_data[1];
    assign Out_PC      = rd_data[2];
    assign Out_BusyA   = rd_busy[0];
    assign Out_BusyB   = rd_busy[1];
    assign Out_BusyC   = rd_busy[2];
    assign Out_AnyBusy = |busy_q;

endmodule
